// File: rtl/c2421_pkg.sv
// Shared types and code constants for the 2421-to-BCD decoder.
package c2421_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] C2421_0 = 4'b0000;
    localparam logic [3:0] C2421_1 = 4'b0001;
    localparam logic [3:0] C2421_2 = 4'b0010;
    localparam logic [3:0] C2421_3 = 4'b0011;
    localparam logic [3:0] C2421_4 = 4'b0100;
    localparam logic [3:0] C2421_5 = 4'b1011;
    localparam logic [3:0] C2421_6 = 4'b1100;
    localparam logic [3:0] C2421_7 = 4'b1101;
    localparam logic [3:0] C2421_8 = 4'b1110;
    localparam logic [3:0] C2421_9 = 4'b1111;

    localparam logic [3:0] ILLEGAL_BCD = 4'd0;

endpackage

// File: rtl/c2421_digit_dec.sv
// Single-digit 2421 to BCD decoder; codes outside the legal ten flag illegal.
module c2421_digit_dec
    import c2421_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] bcd,
    output logic       ill
);

    always_comb begin
        bcd = ILLEGAL_BCD;
        ill = 1'b0;
        case (code)
            C2421_0: bcd = 4'd0;
            C2421_1: bcd = 4'd1;
            C2421_2: bcd = 4'd2;
            C2421_3: bcd = 4'd3;
            C2421_4: bcd = 4'd4;
            C2421_5: bcd = 4'd5;
            C2421_6: bcd = 4'd6;
            C2421_7: bcd = 4'd7;
            C2421_8: bcd = 4'd8;
            C2421_9: bcd = 4'd9;
            default: ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/c2421_to_bcd_seq.sv
// Sequential packed-2421 to packed-BCD decoder, one digit per clock, MS digit first.
// Optional binary output enabled by defining C2421_BINARY_OUT_EN.
module c2421_to_bcd_seq
    import c2421_pkg::*;
#(
    parameter int NDIG  = 4
`ifdef C2421_BINARY_OUT_EN
    ,
    parameter int BIN_W = 14
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*NDIG-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   out_bcd,
    output logic [NDIG-1:0]     out_err
`ifdef C2421_BINARY_OUT_EN
    ,
    output logic [BIN_W-1:0]    out_bin
`endif
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t                  state, state_nxt;
    logic [NDIG-1:0][3:0]    shadow;
    logic [NDIG-1:0][3:0]    bcd_q;
    logic [NDIG-1:0]         err_q;
    logic [IW-1:0]           idx;
    logic [3:0]              dig_bcd;
    logic                    dig_ill;

    // One shared decoder; the shadow digit under conversion is selected by idx.
    c2421_digit_dec u_dec (
        .code (shadow[idx]),
        .bcd  (dig_bcd),
        .ill  (dig_ill)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = CONV;
            CONV:    if (idx == '0)    state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            bcd_q  <= '0;
            err_q  <= '0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    shadow <= in_data;
                    bcd_q  <= '0;
                    err_q  <= '0;
                    idx    <= IW'(NDIG - 1);
                end
                CONV: begin
                    bcd_q[idx] <= dig_bcd;
                    err_q[idx] <= dig_ill;
                    if (idx != '0) idx <= idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_bcd = bcd_q;
    assign out_err = err_q;

`ifdef C2421_BINARY_OUT_EN
    logic [BIN_W-1:0] acc;

    // Horner accumulation works because digits arrive MS first; illegal digits decode to 0.
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (state == IDLE && in_valid)
            acc <= '0;
        else if (state == CONV)
            acc <= acc * BIN_W'(10) + BIN_W'(dig_bcd);
    end

    assign out_bin = acc;
`endif

endmodule

// File: tb/tb_c2421_to_bcd_seq.sv
// Directed self-checking bench for c2421_to_bcd_seq (NDIG=4); out_bin checks follow C2421_BINARY_OUT_EN.
module tb_c2421_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [3:0]  out_err;
`ifdef C2421_BINARY_OUT_EN
    logic [13:0] out_bin;
`endif

    int total = 0;
    int bad   = 0;

    c2421_to_bcd_seq #(.NDIG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err)
`ifdef C2421_BINARY_OUT_EN
        ,
        .out_bin   (out_bin)
`endif
    );

    always #5 clk = ~clk;

    // Drives one word and returns the edge count (from the accepting edge) at which
    // a sink first captures out_valid; to=1 if a bound expired.
    task automatic send_word(input logic [15:0] d, output int lat, output bit to);
        int w;
        to = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) to = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) to = 1'b1;
        lat = lat + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 16'hFFFF; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_bcd !== 16'h0000) begin bad++; $display("FAIL reset_out_bcd got=%h exp=0000", out_bcd); end
        total++; if (out_err !== 4'b0000) begin bad++; $display("FAIL reset_out_err got=%b exp=0000", out_err); end
`ifdef C2421_BINARY_OUT_EN
        total++; if (out_bin !== 14'd0) begin bad++; $display("FAIL reset_out_bin got=%0d exp=0", out_bin); end
`endif
    endtask

    task automatic test_basic();
        int lat; bit to;
        out_ready = 1'b1;
        send_word(16'h1FFB, lat, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=timeout exp=valid"); end
        total++; if (lat != 5) begin bad++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        total++; if (out_bcd !== 16'h1995) begin bad++; $display("FAIL basic_bcd got=%h exp=1995", out_bcd); end
        total++; if (out_err !== 4'b0000) begin bad++; $display("FAIL basic_err got=%b exp=0000", out_err); end
`ifdef C2421_BINARY_OUT_EN
        total++; if (out_bin !== 14'h07CB) begin bad++; $display("FAIL basic_bin got=%0d exp=1995", out_bin); end
`endif
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle got=v%b r%b exp=v0 r1", out_valid, in_ready); end

        send_word(16'h0567, lat, to);
        total++; if (to) begin bad++; $display("FAIL illegal3_timeout got=timeout exp=valid"); end
        total++; if (out_bcd !== 16'h0000) begin bad++; $display("FAIL illegal3_bcd got=%h exp=0000", out_bcd); end
        total++; if (out_err !== 4'b0111) begin bad++; $display("FAIL illegal3_err got=%b exp=0111", out_err); end
`ifdef C2421_BINARY_OUT_EN
        total++; if (out_bin !== 14'd0) begin bad++; $display("FAIL illegal3_bin got=%0d exp=0", out_bin); end
`endif
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [3:0]  codes [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        logic [3:0]  ills  [6]  = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        logic [3:0]  c, v;
        int lat; bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            c = codes[i];
            v = 4'(i);
            send_word({c, c, c, c}, lat, to);
            total++;
            if (to || out_bcd !== {v, v, v, v} || out_err !== 4'b0000) begin
                bad++; $display("FAIL sweep_%0d got=%h/%b exp=%h/0000", i, out_bcd, out_err, {v, v, v, v});
            end
`ifdef C2421_BINARY_OUT_EN
            total++; if (out_bin !== 14'(i * 1111)) begin bad++; $display("FAIL sweep_bin_%0d got=%0d exp=%0d", i, out_bin, i * 1111); end
`endif
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            c = ills[i];
            send_word({4'h1, c, 4'h1, 4'h1}, lat, to);
            total++;
            if (to || out_bcd !== 16'h1011 || out_err !== 4'b0100) begin
                bad++; $display("FAIL illegal_d2_%h got=%h/%b exp=1011/0100", c, out_bcd, out_err);
            end
`ifdef C2421_BINARY_OUT_EN
            total++; if (out_bin !== 14'd1011) begin bad++; $display("FAIL illegal_d2_bin_%h got=%0d exp=1011", c, out_bin); end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit to; int w;
        out_ready = 1'b0;
        send_word(16'h4321, lat, to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout got=timeout exp=valid"); end
        in_data  = 16'h1FFB;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (out_bcd !== 16'h4321 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold_%0d got=%h r%b v%b exp=4321 r0 v1", i, out_bcd, in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=r%b v%b exp=r1 v0", in_ready, out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin @(negedge clk); w++; end
        total++; if (!out_valid || out_bcd !== 16'h1995) begin bad++; $display("FAIL bp_second got=%h v%b exp=1995 v1", out_bcd, out_valid); end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int lat; bit to;
        out_ready = 1'b1;
        in_data   = 16'h1FFB;
        in_valid  = 1'b1;
        @(negedge clk);          // accepted at the edge before this point; idx=3
        in_valid = 1'b0;
        @(negedge clk);          // one digit processed; idx=2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== 16'h0000 || out_err !== 4'b0000) begin
            bad++; $display("FAIL rstmid_state got=r%b v%b %h %b exp=r1 v0 0000 0000", in_ready, out_valid, out_bcd, out_err);
        end
`ifdef C2421_BINARY_OUT_EN
        total++; if (out_bin !== 14'd0) begin bad++; $display("FAIL rstmid_bin got=%0d exp=0", out_bin); end
`endif
        send_word(16'hFFFF, lat, to);
        total++; if (to || out_bcd !== 16'h9999 || out_err !== 4'b0000) begin bad++; $display("FAIL rstmid_after got=%h/%b exp=9999/0000", out_bcd, out_err); end
`ifdef C2421_BINARY_OUT_EN
        total++; if (out_bin !== 14'd9999) begin bad++; $display("FAIL rstmid_after_bin got=%0d exp=9999", out_bin); end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int acc_t[$];
        int cyc;
        out_ready = 1'b1;
        in_data   = 16'h4321;
        in_valid  = 1'b1;
        cyc = 0;
        while (acc_t.size() < 3 && cyc < 60) begin
            if (in_valid && in_ready) acc_t.push_back(cyc);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (acc_t.size() != 3) begin
            bad++; $display("FAIL b2b_count got=%0d exp=3", acc_t.size());
        end else begin
            total++; if (acc_t[1] - acc_t[0] != 6) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=6", acc_t[1] - acc_t[0]); end
            total++; if (acc_t[2] - acc_t[1] != 6) begin bad++; $display("FAIL b2b_gap2 got=%0d exp=6", acc_t[2] - acc_t[1]); end
        end
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        total++; if (!out_valid || out_bcd !== 16'h4321) begin bad++; $display("FAIL b2b_result got=%h v%b exp=4321 v1", out_bcd, out_valid); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_sweep();
        test_backpressure();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
